matrix_serializer: RTL
======================

# matrix_serializer

Downstream stage of the matrix multiplier. Captures a completed result matrix C (m×n words, presented as one flat bus under the c_stb/c_ack handshake) and emits it one word per cycle on a stb/ack word stream, with row/column tags and a last-word flag. It frees the multiplier as soon as C is captured, so the next product can be computed while the previous one drains.

## Interface
- m, 16: rows of C
- n, 16: columns of C
- word_width, 32: bits per element
- col_major, 0: 0 = row-major emit order, 1 = column-major
- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset; synchronous and active-high
- matrix_C  in  m*n*word_width  flat result; element (r,c) at bits [(r*n+c)*word_width +: word_width], bit 0 is MSB of element (0,0) ([0:N-1] ordering)
- c_stb  in  1  upstream: matrix_C valid
- c_ack  out  1  one-cycle pulse: matrix_C captured
- s_word  out  word_width  current element
- s_row  out  clog2(m) (min 1)  row index of s_word
- s_col  out  clog2(n) (min 1)  column index of s_word
- s_last  out  1  s_word is final element of matrix
- s_stb  out  1  s_word/s_row/s_col/s_last valid
- s_ack  in  1  downstream accepts word this cycle
- busy  out  1  matrix held, not fully emitted

## Operation
- States: IDLE, SEND.
- IDLE: if c_stb, copy matrix_C into internal buffer, pulse c_ack for exactly that one cycle, clear row/col counters, go to SEND. Otherwise stay; c_ack low.
- SEND: s_stb high; s_word = buffer element at (s_row, s_col). Transfer occurs on cycle with s_stb && s_ack.
- Counter advance on transfer: row-major increments col, wrapping n-1→0 with row+1; column-major increments row, wrapping m-1→0 with col+1.
- s_last = 1 when (s_row, s_col) = (m-1, n-1) in either order.
- Transfer with s_last: go to IDLE, counters to 0. New capture possible no earlier than the following cycle (no same-cycle capture on last transfer).
- c_stb in SEND is ignored: no capture, no c_ack; upstream holds C and c_stb until acked.
- Upstream rule: deassert c_stb (or present next matrix) the cycle after c_ack; a still-high c_stb on the next return to IDLE is treated as a new matrix.
- s_ack low: all s_* outputs hold stable; s_ack while s_stb low has no effect.
- busy = (state == SEND).

## Timing
- Reset (rst high at posedge): state IDLE, c_ack 0, s_stb 0, s_last 0, s_word 0, s_row 0, s_col 0, busy 0. Buffer contents don't care. Reset mid-SEND abandons the matrix; no further words, no ack.
- c_stb high in IDLE at edge T: c_ack high in cycle T+1 only; s_stb and element 0 valid from T+1.
- Throughput: one word per cycle with s_ack held high; matrix drains in m*n cycles; s_last on cycle T+m*n.
- Minimum spacing between c_ack pulses: m*n+1 cycles.
- All outputs driven from registers (buffer mux selected by registered counters); no combinational path from c_stb or s_ack to any output.
- m=n=1: single word with s_stb and s_last together.

## Structure
- Shared package: state enum (IDLE, SEND), index-width helper (clog2 with minimum 1), element-offset function (r*n+c)*word_width reused by the multiplier.
- One sub-module natural: matrix_index_counter (row/col counters, order select by col_major, wrap and last detection); the top level holds the buffer, FSM and handshake.

## Test plan
- m=2,n=3,w=8, C=0x01..0x06, s_ack held 1 -> c_ack pulse one cycle after c_stb; words 01,02,03,04,05,06 on consecutive cycles, (row,col) (0,0)…(1,2), s_last only on 06.
- Same C, col_major=1 -> order 01,04,02,05,03,06; s_last on 06 at (1,2).
- s_ack toggled 1,0,0,1,… -> each word stable while s_ack low; no duplicates or drops; total six transfers.
- c_stb reasserted with new C=0xA1..0xA6 during SEND -> no c_ack until one cycle after last transfer of first matrix; then A1..A6 follows.
- rst pulsed after third transfer -> all outputs reset next cycle; with c_stb high afterward, fresh capture and emit restarts at element (0,0).
- m=n=1, C=0x5A -> single cycle s_stb=1, s_last=1, s_word=5A, then idle.

Source files
------------

// File: rtl/matrix_serializer_pkg.sv
// Shared definitions for the matrix multiplier / serializer slice.
// Contents: serializer state enum, index-width helper, flat-bus element offset.
package matrix_serializer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   // Counter width for an index over 'count' items; never narrower than 1 bit
   function automatic int unsigned idx_width(input int unsigned count);
      return (count > 1) ? 32'($clog2(count)) : 32'd1;
   endfunction

   // Bit offset of element (r,c) in a flat row-major matrix bus
   function automatic int unsigned elem_offset(input int unsigned r,
                                               input int unsigned c,
                                               input int unsigned cols,
                                               input int unsigned width);
      return ((r * cols) + c) * width;
   endfunction

endpackage

// File: rtl/matrix_serializer_if.sv
// Matrix capture (c_stb/c_ack) and word stream (s_stb/s_ack) bundle.
// slave  : serializer view (receives matrix_C, drives the word stream)
// master : environment view (presents matrix_C, consumes the word stream)
// Signals: matrix_C, c_stb, c_ack, s_word, s_row, s_col, s_last, s_stb, s_ack, busy
interface matrix_serializer_if
   import matrix_serializer_pkg::*;
#(
   parameter int unsigned m          = 16,
   parameter int unsigned n          = 16,
   parameter int unsigned word_width = 32
);
   localparam int unsigned row_w  = idx_width(m);
   localparam int unsigned col_w  = idx_width(n);
   localparam int unsigned flat_w = m * n * word_width;

   logic [0:flat_w-1]     matrix_C;
   logic                  c_stb;
   logic                  c_ack;
   logic [word_width-1:0] s_word;
   logic [row_w-1:0]      s_row;
   logic [col_w-1:0]      s_col;
   logic                  s_last;
   logic                  s_stb;
   logic                  s_ack;
   logic                  busy;

   modport slave (
      input  matrix_C, c_stb, s_ack,
      output c_ack, s_word, s_row, s_col, s_last, s_stb, busy
   );

   modport master (
      output matrix_C, c_stb, s_ack,
      input  c_ack, s_word, s_row, s_col, s_last, s_stb, busy
   );

endinterface

// File: rtl/matrix_index_counter.sv
// Row/column position counter for streaming an m x n matrix in row- or
// column-major order. Provides the registered current position plus the
// position that follows it, and whether that following position is the
// final element.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clear         return to (0,0)
//   advance       step to the next position (wraps to (0,0) after the last)
//   row, col      registered current position
//   next_row_c    position after the current one (combinational)
//   next_col_c
//   next_last_c   next position is (m-1, n-1)
module matrix_index_counter
   import matrix_serializer_pkg::*;
#(
   parameter int unsigned m         = 16,
   parameter int unsigned n         = 16,
   parameter bit          col_major = 1'b0,
   localparam int unsigned row_w    = idx_width(m),
   localparam int unsigned col_w    = idx_width(n)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             advance,
   output logic [row_w-1:0] row,
   output logic [col_w-1:0] col,
   output logic [row_w-1:0] next_row_c,
   output logic [col_w-1:0] next_col_c,
   output logic             next_last_c
);

   localparam logic [row_w-1:0] row_max = row_w'(m - 1);
   localparam logic [col_w-1:0] col_max = col_w'(n - 1);

   // Successor position; the fast index wraps into the slow one, and the
   // slow index wraps to 0 so the final step lands back on (0,0)
   always_comb begin
      next_row_c  = row;
      next_col_c  = col;
      if (col_major) begin
         if (row == row_max) begin
            next_row_c = '0;
            next_col_c = (col == col_max) ? '0 : col + col_w'(1);
         end else begin
            next_row_c = row + row_w'(1);
         end
      end else begin
         if (col == col_max) begin
            next_col_c = '0;
            next_row_c = (row == row_max) ? '0 : row + row_w'(1);
         end else begin
            next_col_c = col + col_w'(1);
         end
      end
      next_last_c = (next_row_c == row_max) && (next_col_c == col_max);
   end

   // Position register
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         row <= '0;
         col <= '0;
      end else if (advance) begin
         row <= next_row_c;
         col <= next_col_c;
      end
   end

endmodule

// File: rtl/matrix_serializer.sv
// Captures a complete m x n result matrix from the multiplier in one cycle
// and streams it out one word per cycle with row/column tags and a last flag.
// The multiplier is released (c_ack) at capture so it can start the next
// product while this one drains.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        matrix_serializer_if.slave:
//                matrix_C/c_stb in, c_ack out (one-cycle capture pulse)
//                s_word/s_row/s_col/s_last/s_stb out, s_ack in
//                busy out (matrix held, not fully emitted)
module matrix_serializer
   import matrix_serializer_pkg::*;
#(
   parameter int unsigned m          = 16,
   parameter int unsigned n          = 16,
   parameter int unsigned word_width = 32,
   parameter bit          col_major  = 1'b0
) (
   input logic               clk,
   input logic               rst,
   matrix_serializer_if.slave bus
);

   localparam int unsigned row_w  = idx_width(m);
   localparam int unsigned col_w  = idx_width(n);
   localparam int unsigned flat_w = m * n * word_width;
   localparam int unsigned off_w  = idx_width(flat_w);

   state_e            state;
   logic [0:flat_w-1] buffer;
   logic              capture_c;
   logic              xfer_c;
   logic [row_w-1:0]  next_row_c;
   logic [col_w-1:0]  next_col_c;
   logic              next_last_c;
   logic [off_w-1:0]  next_off_c;

   assign capture_c  = (state == IDLE) && bus.c_stb;
   assign xfer_c     = (state == SEND) && bus.s_ack;
   assign next_off_c = off_w'(elem_offset(32'(next_row_c), 32'(next_col_c), n, word_width));

   matrix_index_counter #(
      .m         (m),
      .n         (n),
      .col_major (col_major)
   ) u_index (
      .clk         (clk),
      .rst         (rst),
      .clear       (capture_c),
      .advance     (xfer_c),
      .row         (bus.s_row),
      .col         (bus.s_col),
      .next_row_c  (next_row_c),
      .next_col_c  (next_col_c),
      .next_last_c (next_last_c)
   );

   // Matrix holding register; contents are don't-care outside SEND
   always_ff @(posedge clk) begin
      if (capture_c) begin
         buffer <= bus.matrix_C;
      end
   end

   // Capture/send sequencing. s_word is prefetched from the successor
   // position so every stream output comes straight from a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         bus.c_ack  <= 1'b0;
         bus.s_stb  <= 1'b0;
         bus.s_last <= 1'b0;
         bus.s_word <= '0;
         bus.busy   <= 1'b0;
      end else begin
         bus.c_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.c_stb) begin
                  state      <= SEND;
                  bus.c_ack  <= 1'b1;
                  bus.s_stb  <= 1'b1;
                  bus.busy   <= 1'b1;
                  bus.s_word <= bus.matrix_C[0:word_width-1];
                  bus.s_last <= (m * n == 1);
               end
            end
            SEND: begin
               if (bus.s_ack) begin
                  if (bus.s_last) begin
                     state      <= IDLE;
                     bus.s_stb  <= 1'b0;
                     bus.s_last <= 1'b0;
                     bus.busy   <= 1'b0;
                  end else begin
                     bus.s_word <= buffer[next_off_c +: word_width];
                     bus.s_last <= next_last_c;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
